// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Purpose  : Moore-style control unit for a multicycle MIPS datapath. Steps
//            one shared ALU, memory and register file through several cycles
//            per instruction (lw, sw, R-type, beq, addi, j).
// Ports    : clk        - clock, all state changes on the rising edge
//            reset      - synchronous active-high reset (returns to FETCH)
//            op/funct   - opcode and function fields from the instr register
//            zero       - ALU result equals zero
//            IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
//            ALUSrcB, ALUControl, PCSrc, PCEn - datapath controls
//            done       - last cycle of a legal instruction
//            illegal_op - unsupported opcode (DECODE) or funct (EXECUTE)
//            state      - current state code, for debug
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       done,
    output logic       illegal_op,
    output logic [3:0] state
);

    // State encoding (codes are visible on the debug port)
    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXECUTE = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;

    // Opcodes
    localparam logic [5:0] C_OP_RTYPE = 6'b000000;
    localparam logic [5:0] C_OP_J     = 6'b000010;
    localparam logic [5:0] C_OP_BEQ   = 6'b000100;
    localparam logic [5:0] C_OP_ADDI  = 6'b001000;
    localparam logic [5:0] C_OP_LW    = 6'b100011;
    localparam logic [5:0] C_OP_SW    = 6'b101011;

    // ALU operation codes
    localparam logic [2:0] C_ALU_ADD = 3'b000;
    localparam logic [2:0] C_ALU_SUB = 3'b001;
    localparam logic [2:0] C_ALU_AND = 3'b010;
    localparam logic [2:0] C_ALU_OR  = 3'b011;
    localparam logic [2:0] C_ALU_SLT = 3'b101;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic [3:0] w_cur;
    logic       w_funct_ok;
    logic [2:0] w_funct_alu;

    logic       w_iord;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_regdst;
    logic       w_memtoreg;
    logic       w_regwrite;
    logic       w_alusrca;
    logic [1:0] w_alusrcb;
    logic [2:0] w_aluctl;
    logic [1:0] w_pcsrc;
    logic       w_pcwrite;
    logic       w_branch;
    logic       w_done;
    logic       w_illegal;

    // R-type funct decode; unsupported funct yields add with w_funct_ok low
    always_comb begin
        w_funct_ok  = 1'b1;
        w_funct_alu = C_ALU_ADD;
        case (funct)
            6'b100000: w_funct_alu = C_ALU_ADD;
            6'b100010: w_funct_alu = C_ALU_SUB;
            6'b100100: w_funct_alu = C_ALU_AND;
            6'b100101: w_funct_alu = C_ALU_OR;
            6'b101010: w_funct_alu = C_ALU_SLT;
            default:   w_funct_ok  = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    C_OP_LW, C_OP_SW: w_next = S_MEMADR;
                    C_OP_RTYPE:       w_next = S_EXECUTE;
                    C_OP_BEQ:         w_next = S_BRANCH;
                    C_OP_ADDI:        w_next = S_ADDIEX;
                    C_OP_J:           w_next = S_JUMP;
                    default:          w_next = S_FETCH;
                endcase
            end
            S_MEMADR:  w_next = (op == C_OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   w_next = S_MEMWB;
            S_EXECUTE: w_next = w_funct_ok ? S_ALUWB : S_FETCH;
            S_ADDIEX:  w_next = S_ADDIWB;
            default:   w_next = S_FETCH;
        endcase
    end

    // While reset is held the outputs are decoded as if in FETCH, then the
    // side-effecting enables are masked below.
    assign w_cur = reset ? S_FETCH : r_state;

    // Moore output decode
    always_comb begin
        w_iord     = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_regdst   = 1'b0;
        w_memtoreg = 1'b0;
        w_regwrite = 1'b0;
        w_alusrca  = 1'b0;
        w_alusrcb  = 2'b00;
        w_aluctl   = C_ALU_ADD;
        w_pcsrc    = 2'b00;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_done     = 1'b0;
        w_illegal  = 1'b0;
        case (w_cur)
            S_FETCH: begin
                w_irwrite = 1'b1;
                w_pcwrite = 1'b1;
                w_alusrcb = 2'b01;
            end
            S_DECODE: begin
                // Branch target computed speculatively while decoding
                w_alusrcb = 2'b11;
                case (op)
                    C_OP_LW, C_OP_SW, C_OP_RTYPE,
                    C_OP_BEQ, C_OP_ADDI, C_OP_J: w_illegal = 1'b0;
                    default:                     w_illegal = 1'b1;
                endcase
            end
            S_MEMADR, S_ADDIEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
            end
            S_MEMRD: begin
                w_iord = 1'b1;
            end
            S_MEMWB: begin
                w_memtoreg = 1'b1;
                w_regwrite = 1'b1;
                w_done     = 1'b1;
            end
            S_MEMWR: begin
                w_iord     = 1'b1;
                w_memwrite = 1'b1;
                w_done     = 1'b1;
            end
            S_EXECUTE: begin
                w_alusrca = 1'b1;
                w_aluctl  = w_funct_alu;
                w_illegal = ~w_funct_ok;
            end
            S_ALUWB: begin
                w_regdst   = 1'b1;
                w_regwrite = 1'b1;
                w_done     = 1'b1;
            end
            S_BRANCH: begin
                w_alusrca = 1'b1;
                w_aluctl  = C_ALU_SUB;
                w_pcsrc   = 2'b01;
                w_branch  = 1'b1;
                w_done    = 1'b1;
            end
            S_ADDIWB: begin
                w_regwrite = 1'b1;
                w_done     = 1'b1;
            end
            S_JUMP: begin
                w_pcsrc   = 2'b10;
                w_pcwrite = 1'b1;
                w_done    = 1'b1;
            end
            default: begin
                // Unused codes 12-15: everything stays at its default of 0
            end
        endcase
    end

    assign IorD       = w_iord;
    assign RegDst     = w_regdst;
    assign MemtoReg   = w_memtoreg;
    assign ALUSrcA    = w_alusrca;
    assign ALUSrcB    = w_alusrcb;
    assign ALUControl = w_aluctl;
    assign PCSrc      = w_pcsrc;
    assign IRWrite    = w_irwrite  & ~reset;
    assign MemWrite   = w_memwrite & ~reset;
    assign RegWrite   = w_regwrite & ~reset;
    assign done       = w_done     & ~reset;
    assign illegal_op = w_illegal  & ~reset;
    assign PCEn       = (w_pcwrite | (w_branch & zero)) & ~reset;
    assign state      = r_state;

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the multicycle MIPS datapath. It sequences one shared ALU, the memory and the register file across several cycles per instruction using a Moore state machine. It drives the 3-bit ALUControl codes defined for the ALU: 000 add, 001 sub, 010 and, 011 or, 101 slt. It sits beside the datapath and receives op/funct from the instruction register and zero from the ALU.

## Interface
- No parameters.
- clk  in  1  single clock; all state changes on posedge.
- reset  in  1  synchronous, active-high.
- op  in  6  instruction[31:26].
- funct  in  6  instruction[5:0].
- zero  in  1  ALU result == 0.
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  memory write enable.
- IRWrite  out  1  instruction register load.
- RegDst  out  1  write register: 0 = rt, 1 = rd.
- MemtoReg  out  1  write data: 0 = ALUOut, 1 = Data.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  0 = PC, 1 = register A.
- ALUSrcB  out  2  00 = register B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- ALUControl  out  3  ALU operation code (see above).
- PCSrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target.
- PCEn  out  1  PCWrite | (Branch & zero).
- done  out  1  high in the final cycle of each legal instruction.
- illegal_op  out  1  unsupported op or funct detected.
- state  out  4  current state code, for debug.

## Operation
- Supported opcodes: lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010.
- Supported R-type funct values: add 100000→000, sub 100010→001, and 100100→010, or 100101→011, slt 101010→101.
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11.
- Transitions:
  - FETCH→DECODE.
  - DECODE→MEMADR (lw/sw), EXECUTE (R), BRANCH (beq), ADDIEX (addi), JUMP (j). Any other op → FETCH.
  - MEMADR→MEMRD (lw) or MEMWR (sw). MEMRD→MEMWB.
  - EXECUTE→ALUWB if funct is supported, else → FETCH.
  - ADDIEX→ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP → FETCH.
  - Codes 12–15 → FETCH.
- Per-state outputs (any output not listed is 0):
  - FETCH: IRWrite=1, PCWrite=1, ALUSrcB=01, ALUControl=000.
  - DECODE: ALUSrcB=11, ALUControl=000 (branch target precomputed).
  - MEMADR, ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUControl=000.
  - MEMRD: IorD=1.
  - MEMWB: MemtoReg=1, RegWrite=1, done=1.
  - MEMWR: IorD=1, MemWrite=1, done=1.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl=decode(funct). An unsupported funct gives 000 and illegal_op=1.
  - ALUWB: RegDst=1, RegWrite=1, done=1.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=001, PCSrc=01, Branch=1, done=1.
  - ADDIWB: RegWrite=1, done=1.
  - JUMP: PCSrc=10, PCWrite=1, done=1.
  - DECODE with an unsupported op: illegal_op=1.
  - Codes 12–15: all outputs 0.
- An illegal instruction never asserts RegWrite, MemWrite or done. The PC has already advanced by 4 in FETCH.

## Timing
- The state register updates on posedge clk. Outputs are combinational from state. ALUControl and illegal_op in EXECUTE also depend combinationally on funct; illegal_op in DECODE depends on op.
- Reset: on a posedge with reset=1, state←FETCH. This takes priority over any transition, including mid-instruction.
- While reset=1, IRWrite, PCEn, MemWrite, RegWrite, done and illegal_op are forced to 0. All other outputs show FETCH values.
- Cycles per instruction:
  - lw: 5
  - sw: 4
  - R-type: 4
  - addi: 4
  - beq: 3
  - j: 3
  - illegal op: 2
  - illegal funct: 3
- BRANCH: PCEn equals zero in the same cycle.

## Test plan
- Reset then lw (op=100011): states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; done high in the 5th cycle only.
- R-type sequence with funct = 100000, 100010, 100100, 100101, 101010: in EXECUTE, ALUControl = 000, 001, 010, 011, 101 respectively; ALUWB follows with RegDst=1.
- beq with zero=1, then zero=0: in BRANCH, PCEn=1 then PCEn=0; PCSrc=01 and ALUControl=001 in both cases.
- op=111111 (illegal): states FETCH→DECODE→FETCH; illegal_op=1 in DECODE; no RegWrite or MemWrite pulse.
- R-type with funct=000111: illegal_op=1 in EXECUTE, then FETCH; RegWrite stays 0.
- Assert reset in MEMRD of a lw: next state is FETCH; write enables are 0 during reset; a subsequent sw runs 0,1,2,5 with MemWrite=1 and IorD=1 in state 5.
